// File: rtl/ins_mem_loader.sv
// ins_mem_loader: boot loader from a byte stream into INS_MEM.
// Reads a length-prefixed little-endian image and holds the core in reset until it is written.
// Ports:
//   LOADER_Clk_in / LOADER_Reset_in : clock, sync active-high reset
//   LOADER_Byte_Valid_in / LOADER_Byte_InBUS / LOADER_Byte_Ready_Out : byte source handshake
//   LOADER_Insmem_We_Out / _Addr_OutBUS / _Data_OutBUS : INS_MEM write port (registered)
//   LOADER_CoreRun_Out : core reset release (1 = run), LOADER_Done_Out / LOADER_Error_Out : sticky status
module ins_mem_loader #(
   parameter int DATAWIDTH      = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int ADDR_STEP      = 1,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                  LOADER_Clk_in,
   input  logic                  LOADER_Reset_in,
   input  logic                  LOADER_Byte_Valid_in,
   input  logic [7:0]            LOADER_Byte_InBUS,
   output logic                  LOADER_Byte_Ready_Out,
   output logic                  LOADER_Insmem_We_Out,
   output logic [ADDR_WIDTH-1:0] LOADER_Insmem_Addr_OutBUS,
   output logic [DATAWIDTH-1:0]  LOADER_Insmem_Data_OutBUS,
   output logic                  LOADER_CoreRun_Out,
   output logic                  LOADER_Done_Out,
   output logic                  LOADER_Error_Out
);

   typedef enum logic [2:0] {
      S_HDR,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [DATAWIDTH-1:0]  L_DEPTH =
      DATAWIDTH'((2 ** ADDR_WIDTH) / ADDR_STEP);
   localparam logic [31:0]           L_TMO  = 32'(TIMEOUT_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] L_STEP = ADDR_WIDTH'(ADDR_STEP);

   state_t                  r_state;
   logic [1:0]              r_bcnt;
   logic [DATAWIDTH-1:0]    r_shift;
   logic [DATAWIDTH-1:0]    r_n;
   logic [DATAWIDTH-1:0]    r_idx;
   logic [ADDR_WIDTH-1:0]   r_waddr;
   logic [31:0]             r_idle;
   logic                    r_started;
   logic                    r_ready;
   logic                    r_we;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATAWIDTH-1:0]    r_data;
   logic                    r_done;
   logic                    r_err;
   logic                    r_run;

   logic                    w_acc;
   logic                    w_last;
   logic                    w_tmo;
   logic [DATAWIDTH-1:0]    w_word;
   logic [DATAWIDTH-1:0]    w_idx_nx;

   assign w_acc    = LOADER_Byte_Valid_in & r_ready;
   assign w_last   = (r_bcnt == 2'd3);
   // New byte enters at the top; after 4 bytes the first one sits in [7:0].
   assign w_word   = {LOADER_Byte_InBUS, r_shift[DATAWIDTH-1:8]};
   assign w_idx_nx = r_idx + 1'b1;
   // Only ready cycles count as idle, so WRITE never advances the timer.
   assign w_tmo    = (TIMEOUT_CYCLES != 0) && r_started && r_ready &&
                     !w_acc && (r_idle == L_TMO);

   always_ff @(posedge LOADER_Clk_in) begin
      if (LOADER_Reset_in) begin
         r_state   <= S_HDR;
         r_bcnt    <= '0;
         r_shift   <= '0;
         r_n       <= '0;
         r_idx     <= '0;
         r_waddr   <= '0;
         r_idle    <= '0;
         r_started <= 1'b0;
         r_ready   <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_run     <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (w_acc) begin
            r_bcnt    <= r_bcnt + 2'd1;
            r_shift   <= w_word;
            r_idle    <= '0;
            r_started <= 1'b1;
         end else if ((TIMEOUT_CYCLES != 0) && r_started && r_ready) begin
            r_idle <= r_idle + 32'd1;
         end
         if (w_tmo) begin
            r_state <= S_ERROR;
            r_ready <= 1'b0;
            r_err   <= 1'b1;
         end else begin
            unique case (r_state)
               S_HDR: begin
                  r_ready <= 1'b1;
                  if (w_acc && w_last) begin
                     if (w_word == '0) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b0;
                        r_done  <= 1'b1;
                        r_run   <= 1'b1;
                     end else if (w_word > L_DEPTH) begin
                        r_state <= S_ERROR;
                        r_ready <= 1'b0;
                        r_err   <= 1'b1;
                     end else begin
                        r_state <= S_DATA;
                        r_n     <= w_word;
                        r_idx   <= '0;
                        r_waddr <= '0;
                     end
                  end
               end
               S_DATA: begin
                  if (w_acc && w_last) begin
                     r_state <= S_WRITE;
                     r_ready <= 1'b0;
                     r_we    <= 1'b1;
                     r_addr  <= r_waddr;
                     r_data  <= w_word;
                  end
               end
               S_WRITE: begin
                  r_idx   <= w_idx_nx;
                  // Running address wraps modulo 2**ADDR_WIDTH by width.
                  r_waddr <= r_waddr + L_STEP;
                  if (w_idx_nx == r_n) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_run   <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                     r_ready <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign LOADER_Byte_Ready_Out     = r_ready;
   assign LOADER_Insmem_We_Out      = r_we;
   assign LOADER_Insmem_Addr_OutBUS = r_addr;
   assign LOADER_Insmem_Data_OutBUS = r_data;
   assign LOADER_CoreRun_Out        = r_run;
   assign LOADER_Done_Out           = r_done;
   assign LOADER_Error_Out          = r_err;

endmodule
